// File: rtl/div_job_sequencer.sv
// Job FIFO plus issue/capture FSM sitting in front of the iterative divider.
// A watchdog forces a timeout-flagged result so a hung divider never stalls the pipeline.
module div_job_sequencer #(
    parameter int WIDTH   = 10,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sclr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic [WIDTH-1:0]         div_a,
    output logic [WIDTH-1:0]         div_b,
    output logic                     div_start,
    output logic                     div_sclr,
    input  logic                     div_busy,
    input  logic                     div_valid,
    input  logic [WIDTH-1:0]         div_q,
    input  logic                     div_dvz,
    input  logic                     div_ovf,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_q,
    output logic                     out_dvz,
    output logic                     out_ovf,
    output logic                     out_tmo,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT) + 1;
    localparam logic [WW-1:0] TMO_LAST = WW'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    logic [WIDTH-1:0] mem_a_q [DEPTH];
    logic [WIDTH-1:0] mem_b_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [1:0]       state_q, state_d;
    logic [WW-1:0]    wdog_q, wdog_d;
    logic [WIDTH-1:0] div_a_q, div_a_d;
    logic [WIDTH-1:0] div_b_q, div_b_d;
    logic [WIDTH-1:0] res_quot_q, res_quot_d;
    logic             res_dvz_q, res_dvz_d;
    logic             res_ovf_q, res_ovf_d;
    logic             res_tmo_q, res_tmo_d;
    logic             push;
    logic             pop;

    // A push offered together with sclr is dropped, and a full FIFO never accepts
    // even if the head is popped in the same cycle.
    assign in_ready = (count_q != CW'(DEPTH));
    assign push     = in_valid & in_ready & ~sclr;
    assign pop      = (state_q == ST_IDLE) & (count_q != '0) & ~div_busy;

    assign fifo_count = count_q;
    assign div_a      = div_a_q;
    assign div_b      = div_b_q;
    assign div_start  = (state_q == ST_START);
    assign div_sclr   = sclr | ~rst_n;
    assign out_valid  = (state_q == ST_HOLD);
    assign out_q      = res_quot_q;
    assign out_dvz    = res_dvz_q;
    assign out_ovf    = res_ovf_q;
    assign out_tmo    = res_tmo_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a_q[wr_ptr_q] <= in_a;
            mem_b_q[wr_ptr_q] <= in_b;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        state_d    = state_q;
        wdog_d     = wdog_q;
        div_a_d    = div_a_q;
        div_b_d    = div_b_q;
        res_quot_d = res_quot_q;
        res_dvz_d  = res_dvz_q;
        res_ovf_d  = res_ovf_q;
        res_tmo_d  = res_tmo_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    div_a_d = mem_a_q[rd_ptr_q];
                    div_b_d = mem_b_q[rd_ptr_q];
                    state_d = ST_START;
                end
            end
            ST_START: begin
                wdog_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                wdog_d = wdog_q + 1'b1;
                // A real result wins over a timeout reached in the same cycle.
                if (div_valid) begin
                    res_quot_d = div_q;
                    res_dvz_d  = div_dvz;
                    res_ovf_d  = div_ovf;
                    res_tmo_d  = 1'b0;
                    state_d    = ST_HOLD;
                end else if (wdog_q == TMO_LAST) begin
                    res_quot_d = '0;
                    res_dvz_d  = 1'b0;
                    res_ovf_d  = 1'b0;
                    res_tmo_d  = 1'b1;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            wdog_q     <= '0;
            div_a_q    <= '0;
            div_b_q    <= '0;
            res_quot_q <= '0;
            res_dvz_q  <= 1'b0;
            res_ovf_q  <= 1'b0;
            res_tmo_q  <= 1'b0;
        end else if (sclr) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            wdog_q     <= '0;
            div_a_q    <= '0;
            div_b_q    <= '0;
            res_quot_q <= '0;
            res_dvz_q  <= 1'b0;
            res_ovf_q  <= 1'b0;
            res_tmo_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            wdog_q     <= wdog_d;
            div_a_q    <= div_a_d;
            div_b_q    <= div_b_d;
            res_quot_q <= res_quot_d;
            res_dvz_q  <= res_dvz_d;
            res_ovf_q  <= res_ovf_d;
            res_tmo_q  <= res_tmo_d;
        end
    end

endmodule

// File: tb/tb_div_job_sequencer.sv
// Scoreboard bench for div_job_sequencer with a behavioural divider that can be told to hang.
// Inputs change 1 ns after the rising edge; the monitor samples on the falling edge.
module tb_div_job_sequencer;

    localparam int WIDTH   = 10;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic             dvz;
        logic             ovf;
        logic             tmo;
    } res_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             sclr;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] div_b;
    logic             div_start;
    logic             div_sclr;
    logic             div_busy  = 1'b0;
    logic             div_valid = 1'b0;
    logic [WIDTH-1:0] div_q     = '0;
    logic             div_dvz   = 1'b0;
    logic             div_ovf   = 1'b0;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_q;
    logic             out_dvz;
    logic             out_ovf;
    logic             out_tmo;
    logic [2:0]       fifo_count;

    always #5 clk = ~clk;

    div_job_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclr       (sclr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_start  (div_start),
        .div_sclr   (div_sclr),
        .div_busy   (div_busy),
        .div_valid  (div_valid),
        .div_q      (div_q),
        .div_dvz    (div_dvz),
        .div_ovf    (div_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_q      (out_q),
        .out_dvz    (out_dvz),
        .out_ovf    (out_ovf),
        .out_tmo    (out_tmo),
        .fifo_count (fifo_count)
    );

    int   checks = 0;
    int   fails  = 0;
    res_t expQ[$];
    int   cyc = 0;
    int   startCount = 0;
    int   lastStartCyc = 0;
    int   lastRiseCyc = 0;
    logic hang = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Divider model: four cycles busy, then a one-cycle valid; ignores start while hung.
    logic [WIDTH-1:0] ma = '0;
    logic [WIDTH-1:0] mb = '0;
    int               lat = 0;
    always @(posedge clk) begin
        div_valid <= 1'b0;
        if (div_sclr) begin
            div_busy <= 1'b0;
            lat      <= 0;
        end else if (div_start && !hang) begin
            div_busy <= 1'b1;
            lat      <= 4;
            ma       <= div_a;
            mb       <= div_b;
        end else if (div_busy) begin
            lat <= lat - 1;
            if (lat == 1) begin
                div_busy  <= 1'b0;
                div_valid <= 1'b1;
                div_q     <= (mb == '0) ? '1 : ma / mb;
                div_dvz   <= (mb == '0);
                div_ovf   <= 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic res_t mkRes(input int q, input bit dvz, input bit ovf, input bit tmo);
        res_t r;
        r.q   = WIDTH'(q);
        r.dvz = dvz;
        r.ovf = ovf;
        r.tmo = tmo;
        return r;
    endfunction

    // Called 1 ns after a rising edge; returns 1 ns after the accepting edge.
    task automatic applyStimulus(input int a, input int b, input res_t e);
        int guard = 0;
        in_a     = WIDTH'(a);
        in_b     = WIDTH'(b);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("pushAccepted", int'(in_ready), 1);
        expQ.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic waitDrain(input int maxCycles);
        int n = 0;
        while (expQ.size() != 0 && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drainDepth", expQ.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic waitStart(input int maxCycles);
        int n = 0;
        @(negedge clk);
        while (!div_start && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput("startSeen", int'(div_start), 1);
    endtask

    // Monitor: counts start pulses, checks operand stability, pops the scoreboard on handshakes.
    initial begin
        logic prevOutValid;
        res_t got;
        res_t e;
        prevOutValid = 1'b0;
        forever begin
            @(negedge clk);
            if (div_start) begin
                startCount++;
                lastStartCyc = cyc;
            end
            if (out_valid && !prevOutValid) lastRiseCyc = cyc;
            prevOutValid = out_valid;
            if (out_valid) checkOutput("noStartInHold", int'(div_start), 0);
            if (div_busy) begin
                checkOutput("divAStable", int'(div_a), int'(ma));
                checkOutput("divBStable", int'(div_b), int'(mb));
            end
            if (out_valid && out_ready) begin
                checkOutput("pendingExpect", int'(expQ.size() != 0), 1);
                if (expQ.size() != 0) begin
                    e   = expQ.pop_front();
                    got = {out_q, out_dvz, out_ovf, out_tmo};
                    checkOutput("resultQ", int'(got.q), int'(e.q));
                    checkOutput("resultFlags", int'({got.dvz, got.ovf, got.tmo}),
                                int'({e.dvz, e.ovf, e.tmo}));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL globalTimeout: simulation still running, expected to finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int s0;
        rst_n     = 1'b0;
        sclr      = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;

        @(posedge clk);
        #1;
        checkOutput("rstInReady", int'(in_ready), 1);
        checkOutput("rstOutValid", int'(out_valid), 0);
        checkOutput("rstDivStart", int'(div_start), 0);
        checkOutput("rstFifoCount", int'(fifo_count), 0);
        checkOutput("rstDivSclr", int'(div_sclr), 1);
        checkOutput("rstDivA", int'(div_a), 0);
        checkOutput("rstOutQ", int'(out_q), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("runDivSclr", int'(div_sclr), 0);

        $display("[TB] test 1: single job 824/4");
        s0 = startCount;
        applyStimulus(824, 4, mkRes(206, 0, 0, 0));
        waitStart(20);
        repeat (2) @(negedge clk);
        checkOutput("t1DivA", int'(div_a), 824);
        checkOutput("t1DivB", int'(div_b), 4);
        waitDrain(200);
        checkOutput("t1StartPulses", startCount - s0, 1);
        checkOutput("t1InReady", int'(in_ready), 1);

        $display("[TB] test 2: divide by zero then 9/3");
        applyStimulus(100, 0, mkRes(1023, 1, 0, 0));
        applyStimulus(9, 3, mkRes(3, 0, 0, 0));
        waitDrain(200);

        $display("[TB] test 3: backpressure with full FIFO");
        out_ready = 1'b0;
        s0 = startCount;
        applyStimulus(10, 2, mkRes(5, 0, 0, 0));
        applyStimulus(99, 9, mkRes(11, 0, 0, 0));
        applyStimulus(1000, 10, mkRes(100, 0, 0, 0));
        applyStimulus(1023, 1, mkRes(1023, 0, 0, 0));
        applyStimulus(500, 7, mkRes(71, 0, 0, 0));
        repeat (10) @(posedge clk);
        @(negedge clk);
        checkOutput("t3FifoFull", int'(fifo_count), DEPTH);
        checkOutput("t3InReady", int'(in_ready), 0);
        checkOutput("t3OutValid", int'(out_valid), 1);
        @(posedge clk);
        #1;
        fork
            applyStimulus(0, 5, mkRes(0, 0, 0, 0));
            begin
                repeat (4) @(negedge clk);
                checkOutput("t3Stalled", int'(fifo_count), DEPTH);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        waitDrain(500);
        checkOutput("t3StartPulses", startCount - s0, 6);

        $display("[TB] test 4: hung divider watchdog");
        hang = 1'b1;
        applyStimulus(50, 5, mkRes(0, 0, 0, 1));
        waitDrain(300);
        checkOutput("t4TmoLatency", lastRiseCyc - lastStartCyc, TIMEOUT + 1);
        hang = 1'b0;
        applyStimulus(77, 7, mkRes(11, 0, 0, 0));
        waitDrain(200);

        $display("[TB] test 5: async reset mid-WAIT");
        hang = 1'b1;
        applyStimulus(1, 1, mkRes(0, 0, 0, 1));
        applyStimulus(2, 1, mkRes(0, 0, 0, 1));
        applyStimulus(3, 1, mkRes(0, 0, 0, 1));
        applyStimulus(4, 1, mkRes(0, 0, 0, 1));
        repeat (5) @(posedge clk);
        #1;
        checkOutput("t5Queued", int'(fifo_count), 3);
        rst_n = 1'b0;
        #1;
        checkOutput("t5FifoCount", int'(fifo_count), 0);
        checkOutput("t5OutValid", int'(out_valid), 0);
        checkOutput("t5DivSclr", int'(div_sclr), 1);
        checkOutput("t5DivStart", int'(div_start), 0);
        checkOutput("t5DivA", int'(div_a), 0);
        checkOutput("t5InReady", int'(in_ready), 1);
        #2 rst_n = 1'b1;
        expQ.delete();
        hang = 1'b0;
        s0 = startCount;
        repeat (20) @(negedge clk);
        checkOutput("t5NoResult", int'(out_valid), 0);
        checkOutput("t5NoStart", startCount - s0, 0);
        @(posedge clk);
        #1;
        applyStimulus(20, 4, mkRes(5, 0, 0, 0));
        waitDrain(200);

        $display("[TB] test 6: sclr in HOLD with simultaneous push");
        out_ready = 1'b0;
        applyStimulus(30, 3, mkRes(10, 0, 0, 0));
        begin
            int n = 0;
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        checkOutput("t6Hold", int'(out_valid), 1);
        @(posedge clk);
        #1;
        sclr     = 1'b1;
        in_valid = 1'b1;
        in_a     = 10'd5;
        in_b     = 10'd1;
        @(negedge clk);
        checkOutput("t6DivSclr", int'(div_sclr), 1);
        @(posedge clk);
        #1;
        sclr     = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("t6OutValid", int'(out_valid), 0);
        checkOutput("t6FifoCount", int'(fifo_count), 0);
        checkOutput("t6InReady", int'(in_ready), 1);
        expQ.delete();
        s0 = startCount;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("t6StillIdle", int'(out_valid), 0);
        checkOutput("t6NoStart", startCount - s0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
